// File: rtl/pwm_deadtime_pkg.sv
// rtl/pwm_deadtime_pkg.sv - shared types, phase indices and dead-time helper
package pwm_deadtime_pkg;

  typedef enum logic [2:0] {
    OFF,
    DT_TO_HS,
    DT_TO_LS,
    HS_ON,
    LS_ON
  } phase_state_t;

  localparam int PH_A = 0;
  localparam int PH_B = 1;
  localparam int PH_C = 2;

  // A programmed dead time of zero still yields one dead cycle.
  function automatic int unsigned eff_dead(input int unsigned dead_cycles);
    return (dead_cycles == 0) ? 1 : dead_cycles;
  endfunction

endpackage

// File: rtl/pwm_deadtime_if.sv
// rtl/pwm_deadtime_if.sv - controller-side command/status bundle for the gate-drive stage
interface pwm_deadtime_if #(
  parameter int DT_WIDTH = 8,
  parameter int NUM_PH   = 3
);

  logic                en;
  logic [DT_WIDTH-1:0] dead_cycles;
  logic [NUM_PH-1:0]   pwm_in;
  logic                fault_in;
  logic                fault_clr;
  logic [NUM_PH-1:0]   hs_out;
  logic [NUM_PH-1:0]   ls_out;
  logic                fault_latched;
  logic [NUM_PH-1:0]   busy;

  modport master (
    output en, dead_cycles, pwm_in, fault_in, fault_clr,
    input  hs_out, ls_out, fault_latched, busy
  );

  modport slave (
    input  en, dead_cycles, pwm_in, fault_in, fault_clr,
    output hs_out, ls_out, fault_latched, busy
  );

endinterface

// File: rtl/deadtime_phase.sv
// rtl/deadtime_phase.sv - one phase: complementary drive FSM with dead-interval down-counter
module deadtime_phase
  import pwm_deadtime_pkg::*;
#(
  parameter int DT_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rstb,
  input  logic                force_off,
  input  logic                pwm_q,
  input  logic [DT_WIDTH-1:0] dead_cycles,
  output logic                hs,
  output logic                ls,
  output logic                busy
);

  phase_state_t        state, state_nxt;
  logic [DT_WIDTH-1:0] cnt, cnt_nxt;
  logic [DT_WIDTH-1:0] dt_load;
  logic                load;

  // Counter starts at D-1 and the FSM moves on when it reads zero, giving D dead cycles.
  assign dt_load = DT_WIDTH'(eff_dead(32'(dead_cycles)) - 32'd1);

  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      state <= OFF;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    load      = 1'b0;
    if (force_off) begin
      state_nxt = OFF;
      cnt_nxt   = '0;
    end else begin
      unique case (state)
        OFF: begin
          state_nxt = pwm_q ? DT_TO_HS : DT_TO_LS;
          load      = 1'b1;
        end
        DT_TO_HS: begin
          if (!pwm_q) begin
            state_nxt = DT_TO_LS;
            load      = 1'b1;
          end else if (cnt == '0) begin
            state_nxt = HS_ON;
          end else begin
            cnt_nxt = cnt - DT_WIDTH'(1);
          end
        end
        DT_TO_LS: begin
          if (pwm_q) begin
            state_nxt = DT_TO_HS;
            load      = 1'b1;
          end else if (cnt == '0) begin
            state_nxt = LS_ON;
          end else begin
            cnt_nxt = cnt - DT_WIDTH'(1);
          end
        end
        HS_ON: begin
          if (!pwm_q) begin
            state_nxt = DT_TO_LS;
            load      = 1'b1;
          end
        end
        LS_ON: begin
          if (pwm_q) begin
            state_nxt = DT_TO_HS;
            load      = 1'b1;
          end
        end
        default: state_nxt = OFF;
      endcase
      if (load) cnt_nxt = dt_load;
    end
  end

  // Gates decode from the state register only, so hs and ls can never overlap.
  assign hs   = (state == HS_ON);
  assign ls   = (state == LS_ON);
  assign busy = (state == DT_TO_HS) || (state == DT_TO_LS);

endmodule

// File: rtl/pwm_deadtime.sv
// rtl/pwm_deadtime.sv - three-phase dead-time insertion with fault latch and enable gating
module pwm_deadtime
  import pwm_deadtime_pkg::*;
#(
  parameter int DT_WIDTH = 8,
  parameter int NUM_PH   = 3
) (
  input logic           clk,
  input logic           rstb,
  pwm_deadtime_if.slave bus
);

  logic [NUM_PH-1:0] pwm_q;
  logic              en_q;
  logic              fault_q;
  logic              force_off;
  logic [NUM_PH-1:0] hs, ls, busy;

  // Enable is registered alongside the fault latch so both gate the phases one edge later.
  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      pwm_q   <= '0;
      en_q    <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      pwm_q <= bus.pwm_in;
      en_q  <= bus.en;
      if (bus.fault_in)
        fault_q <= 1'b1;
      else if (bus.fault_clr)
        fault_q <= 1'b0;
    end
  end

  assign force_off = fault_q | ~en_q;

  for (genvar i = 0; i < NUM_PH; i++) begin : g_phase
    deadtime_phase #(
      .DT_WIDTH (DT_WIDTH)
    ) u_phase (
      .clk         (clk),
      .rstb        (rstb),
      .force_off   (force_off),
      .pwm_q       (pwm_q[i]),
      .dead_cycles (bus.dead_cycles),
      .hs          (hs[i]),
      .ls          (ls[i]),
      .busy        (busy[i])
    );
  end

  assign bus.hs_out        = hs;
  assign bus.ls_out        = ls;
  assign bus.busy          = busy;
  assign bus.fault_latched = fault_q;

endmodule

// File: doc/pwm_deadtime.md
Name: pwm_deadtime

Overview:
- Three-phase dead-time insertion and shoot-through guard, directly downstream of the FOC top's pwmA_out/pwmB_out/pwmC_out.
- Converts each single-ended PWM command into complementary high-side/low-side gate drive.
- Guarantees a programmable dead interval between switches and forces all gates off on fault.
- Sole block between the controller and the gate-driver pins.

Parameters:
DT_WIDTH, 8, width of the dead-time cycle count
NUM_PH, 3, number of phases (A=0, B=1, C=2)

Ports:
clk  in  1  system clock
rstb  in  1  reset, asynchronous, active-high
en  in  1  output enable; 0 forces every phase to OFF
dead_cycles  in  DT_WIDTH  dead interval in clk cycles; 0 is treated as 1
pwm_in  in  NUM_PH  PWM command from top, same clock domain; bit0=A, bit1=B, bit2=C
fault_in  in  1  synchronous fault request (overcurrent, driver fault)
fault_clr  in  1  single-cycle request to clear the latched fault
hs_out  out  NUM_PH  high-side gate enables
ls_out  out  NUM_PH  low-side gate enables
fault_latched  out  1  sticky fault flag
busy  out  NUM_PH  phase is in a dead interval

Behaviour:
- Reset (rstb=1, asynchronous): all phases to OFF; hs_out=0, ls_out=0, busy=0, fault_latched=0; internal pwm_q=0; counters=0.
- pwm_in is registered once into pwm_q. All outputs are decoded from registered state; no combinational input-to-output path.
- Effective dead time D = max(dead_cycles, 1). dead_cycles is sampled when a dead interval is entered, not during it.
- Per-phase states:
  - OFF: hs=0, ls=0. Leaves to DT_TO_HS if pwm_q=1, or DT_TO_LS if pwm_q=0, when en=1 and fault_latched=0.
  - DT_TO_HS: hs=0, ls=0, busy=1. After D cycles → HS_ON. If pwm_q falls → DT_TO_LS with the counter reloaded.
  - DT_TO_LS: mirror of DT_TO_HS. After D cycles → LS_ON. If pwm_q rises → DT_TO_HS with the counter reloaded.
  - HS_ON: hs=1, ls=0. pwm_q=0 → DT_TO_LS.
  - LS_ON: hs=0, ls=1. pwm_q=1 → DT_TO_HS.
- Timing: edge 0 is the first edge at which pwm_in is sampled at its new level. The conducting switch deasserts at edge 1. The opposite switch asserts at edge 1+D, provided pwm_in is held.
- Pulses shorter than D+1 cycles never turn on the opposite switch; both switches stay off instead.
- Priority, highest first: reset, fault, en=0, normal FSM.
- fault_in=1 at edge N: fault_latched=1 and every phase is OFF from edge N+1. Any state is aborted.
- fault_clr clears fault_latched only if fault_in=0 in the same cycle. fault_clr while fault_in=1 is ignored.
- After a clear, phases restart through a full dead interval. There is never a direct OFF→ON transition.
- en=0: all phases OFF next edge. Re-enable behaves like a fault clear: a full dead interval, then ON.
- Invariant: hs_out[i] & ls_out[i] == 0 on every cycle, including during reset release.
- Counter: down-counter loaded with D-1 on entry to a DT state; transition when it reads 0. No wrap-around; dead_cycles=255 gives 255 cycles.

Decomposition:
- Package pwm_deadtime_pkg:
  - phase_state_t enum {OFF, DT_TO_HS, DT_TO_LS, HS_ON, LS_ON}
  - PH_A/PH_B/PH_C index constants
  - helper function eff_dead(dead_cycles) implementing the max(…,1) rule
- Sub-module deadtime_phase: one FSM plus counter per phase, instantiated NUM_PH times.
- Fault latch and en gating live in pwm_deadtime and are broadcast to the phases as a single force_off signal.

Test Plan:
- Startup: reset, en=1, dead_cycles=4, pwm_in=3'b001 held → phase A hs rises exactly 5 edges after the first sample (edge 1+4); phases B and C ls rise at the same edge; no output high before that.
- Toggle: phase A square wave with 20-cycle half period, dead_cycles=4 → hs/ls each conduct 16 cycles per half; both low for exactly 4 cycles at each edge.
- Narrow pulse: pwm_in[0] high for 3 cycles while LS_ON, D=4 → ls drops, hs never asserts, ls returns after dead time; busy[0] high throughout.
- Zero dead time: dead_cycles=0 → behaves as D=1; the off gap is one cycle.
- Fault: assert fault_in mid-HS_ON → all outputs 0 next edge and fault_latched=1. fault_clr with fault_in=1 → stays latched. fault_clr with fault_in=0 → full dead interval, then resume.
- Mid-run: reset pulse and en toggling during DT_TO_HS → outputs go 0 immediately on reset, and next edge for en=0. The assertion hs_out&ls_out==0 is checked every cycle across all scenarios.
